// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweep sequencer family.
// Holds the 2-bit FSM state encoding used by the sweeper.
package truth_table_sweeper_pkg;

    localparam int SWEEP_STATE_W = 2;

    typedef enum logic [SWEEP_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_settle_counter.sv
// Settle-time counter: cleared by load, advances while enabled, and flags
// the last hold cycle (count == SETTLE-1).
module sweep_settle_counter #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic terminal
);

    localparam int CNT_W = $clog2(SETTLE) + 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load restarts the hold window at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign terminal = (cnt_r == TERM_CNT);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked sweep of all 2**N_IN input vectors into a SoP/PoS pair, capturing
// both outputs into truth vectors and recording the first disagreement.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sop_in,
    input  logic                 pos_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_sop,
    output logic [2**N_IN-1:0]   table_pos,
    output logic                 mismatch,
    output logic [N_IN-1:0]      mismatch_idx
);

    localparam int N_VEC = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(32'd1);

    sweep_state_e    state_r;
    logic [N_IN-1:0] idx_r;
    logic            load_s;
    logic            count_en_s;
    logic            settle_term_s;

    // Reload the settle counter on every entry into APPLY.
    always_comb begin
        load_s     = 1'b0;
        count_en_s = 1'b0;
        if (state_r == ST_IDLE) begin
            load_s = start;
        end else if (state_r == ST_SAMPLE) begin
            load_s = (idx_r != LAST_IDX);
        end else if (state_r == ST_APPLY) begin
            count_en_s = 1'b1;
        end else begin
            load_s     = 1'b0;
            count_en_s = 1'b0;
        end
    end

    sweep_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .en       (count_en_s),
        .terminal (settle_term_s)
    );

    // Sweep FSM with registered vector, status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= {N_IN{1'b0}};
            vec_out      <= {N_IN{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            table_sop    <= {N_VEC{1'b0}};
            table_pos    <= {N_VEC{1'b0}};
            mismatch     <= 1'b0;
            mismatch_idx <= {N_IN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r      <= ST_APPLY;
                        busy         <= 1'b1;
                        idx_r        <= {N_IN{1'b0}};
                        vec_out      <= {N_IN{1'b0}};
                        table_sop    <= {N_VEC{1'b0}};
                        table_pos    <= {N_VEC{1'b0}};
                        mismatch     <= 1'b0;
                        mismatch_idx <= {N_IN{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    if (settle_term_s) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        state_r <= ST_APPLY;
                    end
                end
                ST_SAMPLE: begin
                    table_sop[idx_r] <= sop_in;
                    table_pos[idx_r] <= pos_in;
                    // Only the first disagreeing index is kept.
                    if ((sop_in != pos_in) && !mismatch) begin
                        mismatch     <= 1'b1;
                        mismatch_idx <= idx_r;
                    end else begin
                        mismatch     <= mismatch;
                        mismatch_idx <= mismatch_idx;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= ST_APPLY;
                        idx_r   <= idx_r + IDX_ONE;
                        vec_out <= idx_r + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default, SETTLE=3 and N_IN=3
// instances driven by behavioural SoP/PoS models of known functions.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Instance A: N_IN=2, SETTLE=1, f = ~y (truth vector 4'b0101)
    logic       start_a = 1'b0;
    logic       pos_force = 1'b0;
    logic       sop_a, pos_a, busy_a, done_a, mm_a;
    logic [1:0] vec_a, mmi_a;
    logic [3:0] tsop_a, tpos_a;
    assign sop_a = ~vec_a[0];
    assign pos_a = pos_force ? 1'b1 : ~vec_a[0];

    // Instance B: N_IN=2, SETTLE=3, same function
    logic       start_b = 1'b0;
    logic       sop_b, pos_b, busy_b, done_b, mm_b;
    logic [1:0] vec_b, mmi_b;
    logic [3:0] tsop_b, tpos_b;
    assign sop_b = ~vec_b[0];
    assign pos_b = ~vec_b[0];

    // Instance C: N_IN=3, SETTLE=1, odd parity
    logic       start_c = 1'b0;
    logic       sop_c, pos_c, busy_c, done_c, mm_c;
    logic [2:0] vec_c, mmi_c;
    logic [7:0] tsop_c, tpos_c;
    assign sop_c = ^vec_c;
    assign pos_c = ^vec_c;

    truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sop_in(sop_a), .pos_in(pos_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .table_sop(tsop_a),
        .table_pos(tpos_a), .mismatch(mm_a), .mismatch_idx(mmi_a));

    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sop_in(sop_b), .pos_in(pos_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .table_sop(tsop_b),
        .table_pos(tpos_b), .mismatch(mm_b), .mismatch_idx(mmi_b));

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .start(start_c), .sop_in(sop_c), .pos_in(pos_c),
        .vec_out(vec_c), .busy(busy_c), .done(done_c), .table_sop(tsop_c),
        .table_pos(tpos_c), .mismatch(mm_c), .mismatch_idx(mmi_c));

    int         vec_log [0:64];
    logic       snap_mm;
    logic [3:0] snap_tpos;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    function automatic int cur_vec(input int sel);
        case (sel)
            0: return int'(vec_a);
            1: return int'(vec_b);
            default: return int'(vec_c);
        endcase
    endfunction

    function automatic logic cur_done(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    // Cycle 1 is the cycle after the edge that samples start.
    task automatic run_sweep(input int sel, input bit hold, output int lat);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        if (!hold) set_start(sel, 1'b0);
        lat = 1;
        snap_mm   = mm_a;
        snap_tpos = tpos_a;
        forever begin
            vec_log[lat] = cur_vec(sel);
            if (cur_done(sel) || lat >= 64) break;
            @(negedge clk);
            lat++;
        end
        set_start(sel, 1'b0);
    endtask

    initial begin
        int  lat;
        bit  found;
        bit  seen_done;

        repeat (2) @(negedge clk);
        check_value("rst_vec", 32'(vec_a), 32'd0);
        check_value("rst_busy", 32'(busy_a), 32'd0);
        check_value("rst_done", 32'(done_a), 32'd0);
        check_value("rst_tables", {24'd0, tsop_a, tpos_a}, 32'd0);
        check_value("rst_mismatch", {30'd0, mm_a, 1'b0} | 32'(mmi_a), 32'd0);
        rst_n = 1'b1;

        // Test 1: matched pair, default parameters
        run_sweep(0, 1'b0, lat);
        check_value("t1_latency", 32'(lat), 32'd9);
        for (int c = 1; c <= 8; c++) check_value("t1_vec_seq", 32'(vec_log[c]), 32'((c - 1) / 2));
        check_value("t1_table_sop", 32'(tsop_a), 32'h5);
        check_value("t1_table_pos", 32'(tpos_a), 32'h5);
        check_value("t1_mismatch", 32'(mm_a), 32'd0);
        check_value("t1_mismatch_idx", 32'(mmi_a), 32'd0);
        @(negedge clk);
        check_value("t1_done_pulse", 32'(done_a), 32'd0);
        check_value("t1_busy_idle", 32'(busy_a), 32'd0);
        check_value("t1_vec_hold", 32'(vec_a), 32'd3);

        // Test 2: PoS stuck at 1
        pos_force = 1'b1;
        run_sweep(0, 1'b0, lat);
        check_value("t2_latency", 32'(lat), 32'd9);
        check_value("t2_table_sop", 32'(tsop_a), 32'h5);
        check_value("t2_table_pos", 32'(tpos_a), 32'hF);
        check_value("t2_mismatch", 32'(mm_a), 32'd1);
        check_value("t2_mismatch_idx", 32'(mmi_a), 32'd1);
        pos_force = 1'b0;

        // Test 3: start held through sweep, results cleared on accept
        run_sweep(0, 1'b1, lat);
        check_value("t3_cleared_mm", 32'(snap_mm), 32'd0);
        check_value("t3_cleared_tpos", 32'(snap_tpos), 32'd0);
        check_value("t3_latency", 32'(lat), 32'd9);
        check_value("t3_table_pos", 32'(tpos_a), 32'h5);
        check_value("t3_mismatch", 32'(mm_a), 32'd0);
        repeat (2) @(negedge clk);
        check_value("t3_no_resweep", 32'(busy_a), 32'd0);
        run_sweep(0, 1'b0, lat);
        check_value("t3_restart_latency", 32'(lat), 32'd9);
        check_value("t3_restart_table", {24'd0, tsop_a, tpos_a}, 32'h55);

        // Test 4: reset while idx=2
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (vec_a == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        check_value("t4_reached_idx2", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_value("t4_busy", 32'(busy_a), 32'd0);
        check_value("t4_vec", 32'(vec_a), 32'd0);
        check_value("t4_tables", {24'd0, tsop_a, tpos_a}, 32'd0);
        check_value("t4_mismatch", {30'd0, mm_a, done_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_a || busy_a) seen_done = 1'b1;
        end
        check_value("t4_no_done", 32'(seen_done), 32'd0);
        run_sweep(0, 1'b0, lat);
        check_value("t4_resweep_latency", 32'(lat), 32'd9);
        check_value("t4_resweep_table", {24'd0, tsop_a, tpos_a}, 32'h55);

        // Test 5: SETTLE=3
        run_sweep(1, 1'b0, lat);
        check_value("t5_latency", 32'(lat), 32'd17);
        check_value("t5_vec_c4", 32'(vec_log[4]), 32'd0);
        check_value("t5_vec_c5", 32'(vec_log[5]), 32'd1);
        check_value("t5_vec_c16", 32'(vec_log[16]), 32'd3);
        check_value("t5_tables", {24'd0, tsop_b, tpos_b}, 32'h55);
        check_value("t5_mismatch", {29'd0, mm_b, mmi_b}, 32'd0);
        @(negedge clk);
        check_value("t5_busy_idle", 32'(busy_b), 32'd0);

        // Test 6: N_IN=3 parity
        run_sweep(2, 1'b0, lat);
        check_value("t6_latency", 32'(lat), 32'd17);
        check_value("t6_table_sop", 32'(tsop_c), 32'h96);
        check_value("t6_table_pos", 32'(tpos_c), 32'h96);
        check_value("t6_mismatch", {28'd0, mm_c, mmi_c}, 32'd0);
        check_value("t6_vec_last", 32'(vec_c), 32'd7);
        @(negedge clk);
        check_value("t6_busy_idle", 32'(busy_c), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
